// File: rtl/vx_tag_flush_ctrl.sv
// Per-bank tag-store invalidation sequencer: walks every line of the bank writing valid=0,
// once after reset and again for each accepted flush request.
module vx_tag_flush_ctrl #(
  parameter int unsigned CACHE_SIZE      = 16384,
  parameter int unsigned CACHE_LINE_SIZE = 64,
  parameter int unsigned NUM_BANKS       = 4,
  localparam int unsigned LINES_PER_BANK = CACHE_SIZE / (CACHE_LINE_SIZE * NUM_BANKS),
  localparam int unsigned LINE_SEL_BITS  = (LINES_PER_BANK > 1) ? $clog2(LINES_PER_BANK) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_req_valid,
  output logic                     flush_req_ready,
  output logic                     flush_done,
  input  logic                     stall,
  output logic                     busy,
  output logic                     tag_fill,
  output logic                     tag_is_flush,
  output logic [LINE_SEL_BITS-1:0] tag_addr
);

  typedef enum logic [2:0] {
    StStart,
    StInit,
    StIdle,
    StFlush,
    StDone
  } state_e;

  localparam logic [LINE_SEL_BITS-1:0] LastLine = LINE_SEL_BITS'(LINES_PER_BANK - 1);

  state_e                   state_q, state_d;
  logic [LINE_SEL_BITS-1:0] ctr_q, ctr_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StStart;
      ctr_q   <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    ctr_d           = ctr_q;
    busy            = 1'b1;
    tag_fill        = 1'b0;
    flush_req_ready = 1'b0;
    flush_done      = 1'b0;

    unique case (state_q)
      StStart: state_d = StInit;
      StInit, StFlush: begin
        // A stalled cycle performs no write, so the counter simply waits.
        tag_fill = !stall;
        if (!stall) begin
          if (ctr_q == LastLine) begin
            ctr_d   = '0;
            state_d = (state_q == StInit) ? StIdle : StDone;
          end else begin
            ctr_d = ctr_q + LINE_SEL_BITS'(1);
          end
        end
      end
      StIdle: begin
        busy            = 1'b0;
        flush_req_ready = 1'b1;
        if (flush_req_valid) begin
          state_d = StFlush;
          ctr_d   = '0;
        end
      end
      StDone: begin
        flush_done = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StStart;
    endcase
  end

  assign tag_addr     = ctr_q;
  assign tag_is_flush = 1'b1;

endmodule
